// File: rtl/pipelined_ctrl_unit.sv
// Registered RV32IM decode/control stage with valid/ready handshakes and a hold FSM for M-extension ops.
// Optional CSR decoding (opcode 1110011) is enabled by defining the macro ZICSR_EN.
module pipelined_ctrl_unit #(
  parameter int ILEN           = 32,
  parameter int ALUSEL_W       = 5,
  parameter int MULDIV_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ILEN-1:0]     instruction,
  input  logic                flush_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                regWEn,
  output logic                MemRW,
  output logic                memRead,
  output logic                BSel,
  output logic                ASel,
  output logic                BrUn,
  output logic                branch,
  output logic                is_jalr,
  output logic                flush,
  output logic                trapReq,
  output logic                illegal,
  output logic                busy,
  output logic [1:0]          WBSel,
  output logic [ALUSEL_W-1:0] ALUSel,
  output logic [2:0]          csr_op
);

  localparam int CNT_W = (MULDIV_LATENCY < 2) ? 1 : $clog2(MULDIV_LATENCY + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [ALUSEL_W-1:0] ALU_ADD    = ALUSEL_W'(5'b00000);
  localparam logic [ALUSEL_W-1:0] ALU_SUB    = ALUSEL_W'(5'b00001);
  localparam logic [ALUSEL_W-1:0] ALU_AND    = ALUSEL_W'(5'b00010);
  localparam logic [ALUSEL_W-1:0] ALU_OR     = ALUSEL_W'(5'b00011);
  localparam logic [ALUSEL_W-1:0] ALU_XOR    = ALUSEL_W'(5'b00100);
  localparam logic [ALUSEL_W-1:0] ALU_SLL    = ALUSEL_W'(5'b00101);
  localparam logic [ALUSEL_W-1:0] ALU_SRL    = ALUSEL_W'(5'b00110);
  localparam logic [ALUSEL_W-1:0] ALU_SRA    = ALUSEL_W'(5'b00111);
  localparam logic [ALUSEL_W-1:0] ALU_SLT    = ALUSEL_W'(5'b01000);
  localparam logic [ALUSEL_W-1:0] ALU_SLTU   = ALUSEL_W'(5'b01001);
  localparam logic [ALUSEL_W-1:0] ALU_LUI    = ALUSEL_W'(5'b01010);
  localparam logic [ALUSEL_W-1:0] ALU_MUL    = ALUSEL_W'(5'b01011);
  localparam logic [ALUSEL_W-1:0] ALU_MULH   = ALUSEL_W'(5'b01100);
  localparam logic [ALUSEL_W-1:0] ALU_MULHSU = ALUSEL_W'(5'b01101);
  localparam logic [ALUSEL_W-1:0] ALU_MULHU  = ALUSEL_W'(5'b01110);
  localparam logic [ALUSEL_W-1:0] ALU_DIV    = ALUSEL_W'(5'b01111);
  localparam logic [ALUSEL_W-1:0] ALU_DIVU   = ALUSEL_W'(5'b10000);
  localparam logic [ALUSEL_W-1:0] ALU_REM    = ALUSEL_W'(5'b10001);
  localparam logic [ALUSEL_W-1:0] ALU_REMU   = ALUSEL_W'(5'b10010);

  typedef struct packed {
    logic                regWEn;
    logic                MemRW;
    logic                memRead;
    logic                BSel;
    logic                ASel;
    logic                BrUn;
    logic                branch;
    logic                is_jalr;
    logic                flush;
    logic                trapReq;
    logic                illegal;
    logic [1:0]          WBSel;
    logic [ALUSEL_W-1:0] ALUSel;
    logic [2:0]          csr_op;
  } ctrl_t;

  typedef enum logic {IDLE, MD_WAIT} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             out_valid_reg;
  ctrl_t            word_reg;
  ctrl_t            dec;
  logic             ill;
  logic             is_m_op;
  logic             accept;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode  = instruction[6:0];
  assign funct3  = instruction[14:12];
  assign funct7  = instruction[31:25];
  assign is_m_op = (opcode == OP_R) && (funct7 == 7'b0000001);

  always_comb begin
    dec = '0;
    ill = 1'b0;
    case (opcode)
      OP_R: begin
        dec.regWEn = 1'b1;
        dec.WBSel  = 2'b01;
        if (funct7 == 7'b0000001) begin
          case (funct3)
            3'b000:  dec.ALUSel = ALU_MUL;
            3'b001:  dec.ALUSel = ALU_MULH;
            3'b010:  dec.ALUSel = ALU_MULHSU;
            3'b011:  dec.ALUSel = ALU_MULHU;
            3'b100:  dec.ALUSel = ALU_DIV;
            3'b101:  dec.ALUSel = ALU_DIVU;
            3'b110:  dec.ALUSel = ALU_REM;
            default: dec.ALUSel = ALU_REMU;
          endcase
        end else if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec.ALUSel = ALU_ADD;
            3'b001:  dec.ALUSel = ALU_SLL;
            3'b010:  dec.ALUSel = ALU_SLT;
            3'b011:  dec.ALUSel = ALU_SLTU;
            3'b100:  dec.ALUSel = ALU_XOR;
            3'b101:  dec.ALUSel = ALU_SRL;
            3'b110:  dec.ALUSel = ALU_OR;
            default: dec.ALUSel = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.ALUSel = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.ALUSel = ALU_SRA;
        end else begin
          ill = 1'b1;
        end
      end
      OP_I: begin
        dec.regWEn = 1'b1;
        dec.BSel   = 1'b1;
        dec.WBSel  = 2'b01;
        case (funct3)
          3'b000: dec.ALUSel = ALU_ADD;
          3'b010: dec.ALUSel = ALU_SLT;
          3'b011: dec.ALUSel = ALU_SLTU;
          3'b100: dec.ALUSel = ALU_XOR;
          3'b110: dec.ALUSel = ALU_OR;
          3'b111: dec.ALUSel = ALU_AND;
          3'b001: begin
            dec.ALUSel = ALU_SLL;
            ill        = (funct7 != 7'b0000000);
          end
          default: begin
            // Shift-right immediates: funct7 selects logical vs arithmetic.
            if (funct7 == 7'b0000000)      dec.ALUSel = ALU_SRL;
            else if (funct7 == 7'b0100000) dec.ALUSel = ALU_SRA;
            else                           ill        = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        dec.regWEn  = 1'b1;
        dec.memRead = 1'b1;
        dec.BSel    = 1'b1;
        ill         = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        dec.MemRW = 1'b1;
        dec.BSel  = 1'b1;
        ill       = funct3[2] || (funct3 == 3'b011);
      end
      OP_BR: begin
        dec.branch = 1'b1;
        dec.ASel   = 1'b1;
        dec.BSel   = 1'b1;
        dec.BrUn   = funct3[2] & funct3[1];
        ill        = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        dec.regWEn = 1'b1;
        dec.ASel   = 1'b1;
        dec.BSel   = 1'b1;
        dec.WBSel  = 2'b10;
        dec.flush  = 1'b1;
      end
      OP_JALR: begin
        dec.regWEn  = 1'b1;
        dec.BSel    = 1'b1;
        dec.WBSel   = 2'b10;
        dec.flush   = 1'b1;
        dec.is_jalr = 1'b1;
        ill         = (funct3 != 3'b000);
      end
      OP_LUI: begin
        dec.regWEn = 1'b1;
        dec.BSel   = 1'b1;
        dec.WBSel  = 2'b01;
        dec.ALUSel = ALU_LUI;
      end
      OP_AUIPC: begin
        dec.regWEn = 1'b1;
        dec.ASel   = 1'b1;
        dec.BSel   = 1'b1;
        dec.WBSel  = 2'b01;
      end
      OP_SYS: begin
        // Only the exact ECALL (0x00000073) and EBREAK (0x00100073) words trap without being illegal.
        if (funct3 == 3'b000) begin
          if (instruction[31:7] == 25'h0000000 || instruction[31:7] == 25'h0002000) dec.trapReq = 1'b1;
          else                                                                       ill         = 1'b1;
        end
`ifdef ZICSR_EN
        else if (funct3 != 3'b100) begin
          dec.regWEn = 1'b1;
          dec.WBSel  = 2'b11;
          dec.csr_op = funct3;
          dec.ALUSel = '1;
        end
`endif
        else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec         = '0;
      dec.trapReq = 1'b1;
      dec.illegal = 1'b1;
      dec.ALUSel  = '1;
    end
  end

  assign in_ready = !rst && !flush_in && (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      word_reg      <= '0;
    end else if (flush_in) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            word_reg <= dec;
            if (is_m_op && MULDIV_LATENCY > 1) begin
              state_reg     <= MD_WAIT;
              cnt_reg       <= CNT_W'(MULDIV_LATENCY - 1);
              out_valid_reg <= 1'b0;
            end else begin
              out_valid_reg <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        MD_WAIT: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = (state_reg == MD_WAIT);
  assign out_valid = out_valid_reg;
  assign regWEn    = word_reg.regWEn;
  assign MemRW     = word_reg.MemRW;
  assign memRead   = word_reg.memRead;
  assign BSel      = word_reg.BSel;
  assign ASel      = word_reg.ASel;
  assign BrUn      = word_reg.BrUn;
  assign branch    = word_reg.branch;
  assign is_jalr   = word_reg.is_jalr;
  assign flush     = word_reg.flush;
  assign trapReq   = word_reg.trapReq;
  assign illegal   = word_reg.illegal;
  assign WBSel     = word_reg.WBSel;
  assign ALUSel    = word_reg.ALUSel;
  assign csr_op    = word_reg.csr_op;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Scoreboard bench for pipelined_ctrl_unit: directed scenarios followed by randomized traffic,
// checked against a table-driven decode model and a cycle-count timing model.
module tb_pipelined_ctrl_unit;
  localparam int LAT = 4;
`ifdef ZICSR_EN
  localparam bit ZICSR = 1'b1;
`else
  localparam bit ZICSR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, in_valid = 1'b0, flush_in = 1'b0, out_ready = 1'b0;
  logic [31:0] instruction = '0;
  logic in_ready, out_valid, regWEn, MemRW, memRead, BSel, ASel, BrUn, branch, is_jalr;
  logic flush, trapReq, illegal, busy;
  logic [1:0] WBSel;
  logic [4:0] ALUSel;
  logic [2:0] csr_op;

  always #5 clk = ~clk;

  pipelined_ctrl_unit #(.ILEN(32), .ALUSEL_W(5), .MULDIV_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .flush_in(flush_in), .out_valid(out_valid), .out_ready(out_ready), .regWEn(regWEn),
    .MemRW(MemRW), .memRead(memRead), .BSel(BSel), .ASel(ASel), .BrUn(BrUn), .branch(branch),
    .is_jalr(is_jalr), .flush(flush), .trapReq(trapReq), .illegal(illegal), .busy(busy),
    .WBSel(WBSel), .ALUSel(ALUSel), .csr_op(csr_op)
  );

  typedef struct packed {
    logic regWEn, MemRW, memRead, BSel, ASel, BrUn, branch, is_jalr, flush, trapReq, illegal;
    logic [1:0] WBSel;
    logic [4:0] ALUSel;
    logic [2:0] csr_op;
  } word_t;

  typedef struct {
    word_t       w;
    int          acc;
    int          lat;
    logic [31:0] ins;
  } sb_t;

  word_t act;
  assign act = {regWEn, MemRW, memRead, BSel, ASel, BrUn, branch, is_jalr, flush, trapReq,
                illegal, WBSel, ALUSel, csr_op};

  sb_t sbq[$];
  int  checks = 0, failures = 0, cyc = 0, md_until = 0;
  bit  clear_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp,
                       input logic [31:0] ins);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d ins=%h got=%h expected=%h", name, cyc, ins, got, exp);
    end
  endtask

  // Reference decode built from the instruction-set tables, not from the stage's structure.
  function automatic word_t ref_decode(input logic [31:0] ins);
    word_t r;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit ok;
    logic [4:0] base[8];
    base = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd4, 5'd6, 5'd3, 5'd2};
    r = '0; ok = 1'b1;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    case (op)
      7'h33: begin
        r.regWEn = 1; r.WBSel = 2'b01;
        if (f7 == 7'h01)                 r.ALUSel = 5'd11 + 5'(f3);
        else if (f7 == 7'h00)            r.ALUSel = base[f3];
        else if (f7 == 7'h20 && f3 == 0) r.ALUSel = 5'd1;
        else if (f7 == 7'h20 && f3 == 5) r.ALUSel = 5'd7;
        else ok = 0;
      end
      7'h13: begin
        r.regWEn = 1; r.BSel = 1; r.WBSel = 2'b01; r.ALUSel = base[f3];
        if (f3 == 1 && f7 != 0) ok = 0;
        if (f3 == 5) begin
          if (f7 == 7'h20) r.ALUSel = 5'd7;
          else if (f7 != 0) ok = 0;
        end
      end
      7'h03: begin r.regWEn = 1; r.memRead = 1; r.BSel = 1; ok = (f3 inside {0, 1, 2, 4, 5}); end
      7'h23: begin r.MemRW = 1; r.BSel = 1; ok = (f3 <= 2); end
      7'h63: begin r.branch = 1; r.ASel = 1; r.BSel = 1; r.BrUn = (f3 >= 6); ok = !(f3 inside {2, 3}); end
      7'h6F: begin r.regWEn = 1; r.ASel = 1; r.BSel = 1; r.WBSel = 2'b10; r.flush = 1; end
      7'h67: begin r.regWEn = 1; r.BSel = 1; r.WBSel = 2'b10; r.flush = 1; r.is_jalr = 1; ok = (f3 == 0); end
      7'h37: begin r.regWEn = 1; r.BSel = 1; r.WBSel = 2'b01; r.ALUSel = 5'd10; end
      7'h17: begin r.regWEn = 1; r.ASel = 1; r.BSel = 1; r.WBSel = 2'b01; end
      7'h73: begin
        if (ins == 32'h00000073 || ins == 32'h00100073) r.trapReq = 1;
        else if (ZICSR && f3 != 0 && f3 != 4) begin
          r.regWEn = 1; r.WBSel = 2'b11; r.csr_op = f3; r.ALUSel = 5'h1f;
        end else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      r = '0; r.trapReq = 1; r.illegal = 1; r.ALUSel = 5'h1f;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    logic [6:0] ops[10];
    logic [6:0] f7s[4];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
    r = $urandom;
    f7s[3] = r[31:25];
    case ($urandom_range(0, 12))
      10: r = ($urandom_range(0, 1) == 1) ? 32'h00100073 : 32'h00000073;
      11: ;
      12: begin r[6:0] = 7'h33; r[31:25] = 7'h01; end
      default: begin
        r[6:0] = ops[$urandom_range(0, 9)];
        r[31:25] = f7s[$urandom_range(0, 3)];
      end
    endcase
    return r;
  endfunction

  // One cycle of stimulus; acceptance and the timing model are evaluated at the falling edge.
  task automatic cyc_drive(input logic v, input logic [31:0] ins, input logic rdy,
                           input logic fl, input logic r);
    sb_t e;
    bit  is_m;
    @(posedge clk); #1;
    if (clear_pending) begin
      sbq.delete();
      clear_pending = 1'b0;
    end
    in_valid = v; instruction = ins; out_ready = rdy; flush_in = fl; rst = r;
    @(negedge clk);
    check("in_ready", in_ready, !r && !fl && (cyc >= md_until) && (!out_valid || rdy), ins);
    check("busy", busy, (cyc < md_until), ins);
    if (r || fl) begin
      clear_pending = 1'b1;
      md_until = 0;
    end else if (in_valid && in_ready) begin
      is_m = (ins[6:0] == 7'h33) && (ins[31:25] == 7'h01);
      e.w = ref_decode(ins); e.acc = cyc; e.ins = ins;
      e.lat = (is_m && LAT > 1) ? LAT : 1;
      if (is_m && LAT > 1) md_until = cyc + LAT;
      sbq.push_back(e);
    end
  endtask

  // Monitor: checks latency and content on each fresh presentation, stability while held.
  initial begin
    bit    prev_hold = 1'b0;
    word_t prev_act = '0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (prev_hold) begin
          check("hold_stable", act, prev_act, (sbq.size() > 0) ? sbq[0].ins : 32'h0);
        end else if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out_valid cyc=%0d got=1 expected=0", cyc);
        end else begin
          check("latency", cyc - sbq[0].acc, sbq[0].lat, sbq[0].ins);
          check("decode", act, sbq[0].w, sbq[0].ins);
        end
        if (out_ready && sbq.size() > 0) void'(sbq.pop_front());
        prev_hold = !out_ready;
        prev_act  = act;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    // Reset
    repeat (3) cyc_drive(1'b1, 32'h002081B3, 1'b1, 1'b0, 1'b1);
    cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("reset_word", act, 32'h0, 32'h0);
    check("reset_valid", out_valid, 1'b0, 32'h0);
    // ADD, MUL, DIV with the stage blocked during the M-op wait
    cyc_drive(1'b1, 32'h002081B3, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b1, 32'h022081B3, 1'b1, 1'b0, 1'b0);
    repeat (LAT - 1) cyc_drive(1'b1, 32'h002081B3, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b1, 32'h0220C1B3, 1'b1, 1'b0, 1'b0);
    repeat (LAT) cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    // BLTU held by a stalled consumer
    cyc_drive(1'b1, 32'h0020E463, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc_drive(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0);
    cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Illegal word, ECALL, CSRRW
    cyc_drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b1, 32'h00000073, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b1, 32'h30529073, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    // MUL killed by flush two cycles after acceptance
    cyc_drive(1'b1, 32'h022081B3, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b1, 32'h002081B3, 1'b0, 1'b1, 1'b0);
    cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (LAT + 1) cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Reset in the middle of an M-op wait
    cyc_drive(1'b1, 32'h022081B3, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("rst_mid_word", act, 32'h0, 32'h022081B3);
    check("rst_mid_valid", out_valid, 1'b0, 32'h022081B3);
    // Randomized traffic with back-pressure, flushes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic fl, rr;
      fl = ($urandom_range(0, 39) == 0);
      rr = ($urandom_range(0, 299) == 0);
      cyc_drive($urandom_range(0, 3) != 0, rand_ins(),
                fl ? 1'b0 : ($urandom_range(0, 3) != 0), fl, rr);
    end
    repeat (LAT + 4) cyc_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("drain_empty", sbq.size(), 0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
